// File: rtl/subtractor_pkg.sv
// Shared types and helpers for the nibble-serial subtractor: FSM states,
// slice width and the signed-overflow rule.
package subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Subtraction overflows when the operands differ in sign and the result
  // sign differs from the minuend.
  function automatic logic signed_overflow(input logic a_msb,
                                           input logic b_msb,
                                           input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/nibble_ks_adder_cin.sv
// Combinational 4-bit Kogge-Stone adder with carry-in folded into the
// bit-0 generate term.
module nibble_ks_adder_cin
  import subtractor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [3:0] g0, p0, g1, g2;
  logic [3:2] p1;

  // NOTE: every variable gets a full assignment before any partial update, so
  // this block is pure combinational logic and no latch is inferred.
  always_comb begin
    p0    = a ^ b;
    g0    = a & b;
    g0[0] = g0[0] | (p0[0] & cin);

    g1    = g0;
    for (int i = 1; i < 4; i++) begin
      g1[i] = g0[i] | (p0[i] & g0[i-1]);
    end
    p1[2] = p0[2] & p0[1];
    p1[3] = p0[3] & p0[2];

    g2    = g1;
    g2[2] = g1[2] | (p1[2] & g1[0]);
    g2[3] = g1[3] | (p1[3] & g1[1]);

    // g2[i] is the carry out of bit i.
    sum  = p0 ^ {g2[2:0], cin};
    cout = g2[3];
  end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor computing A + ~B + 1 one nibble per clock,
// with valid/ready handshakes on both sides and borrow/overflow flags.
module nibble_serial_subtractor
  import subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 8");
  end

  state_e state, state_nxt;

  logic [WIDTH-1:0]    a_reg, nb_reg;
  logic                carry;
  logic [IDX_W-1:0]    idx;
  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
    assign a_nib[i] = a_reg[i*NIBBLE_W +: NIBBLE_W];
    assign b_nib[i] = nb_reg[i*NIBBLE_W +: NIBBLE_W];
  end

  nibble_ks_adder_cin u_slice (
    .a    (a_nib[idx]),
    .b    (b_nib[idx]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)        state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // NOTE: the operand and result registers are reset too, so an aborted
  // operation leaves nothing behind that could be mistaken for a result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      nb_reg     <= '0;
      carry      <= 1'b1;
      idx        <= '0;
      difference <= '0;
      borrow     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_reg  <= operand_a;
          nb_reg <= ~operand_b;
          carry  <= 1'b1;
          idx    <= '0;
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) difference[i*NIBBLE_W +: NIBBLE_W] <= slice_sum;
          end
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            borrow   <= ~slice_cout;
            overflow <= signed_overflow(a_reg[WIDTH-1], ~nb_reg[WIDTH-1],
                                        slice_sum[NIBBLE_W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH=16) with a
// short randomized scoreboard pass at the end.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] difference;
  logic        borrow;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .difference (difference),
    .borrow     (borrow),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns at acceptance edge + 1ns.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("start_ready", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    operand_a = a;
    operand_b = b;
    step();
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_result(input string tag, input int exp_cycles);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, exp_cycles);
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed,
                              input logic eb, input logic eo);
    check({tag, "_result"}, {13'd0, out_valid, difference, borrow, overflow},
          {13'd0, 1'b1, ed, eb, eo});
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_release"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    logic [15:0] held_d;
    logic        held_b, held_o;
    logic        ok;
    logic [15:0] ra, rb, rd;
    logic        rbr, rov;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operand_a = '0;
    operand_b = '0;
    #1;
    check("reset_state", {13'd0, in_ready, out_valid, borrow, overflow},
          {13'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_difference", {16'd0, difference}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // Basic subtraction, exact latency.
    start_op(16'h1234, 16'h0234);
    wait_result("basic", 4);
    check_result("basic", 16'h1000, 1'b0, 1'b0);
    release_result("basic");

    start_op(16'h8000, 16'h0001);
    wait_result("neg_ovf", 4);
    check_result("neg_ovf", 16'h7FFF, 1'b0, 1'b1);
    release_result("neg_ovf");

    start_op(16'h7FFF, 16'hFFFF);
    wait_result("pos_ovf", 4);
    check_result("pos_ovf", 16'h8000, 1'b1, 1'b1);
    release_result("pos_ovf");

    // Busy rejection: a pulse during RUN must not disturb the result.
    start_op(16'h1234, 16'h0234);
    in_valid  = 1'b1;
    operand_a = 16'hFFFF;
    operand_b = 16'h0000;
    step();
    in_valid = 1'b0;
    wait_result("busy_reject", 3);
    check_result("busy_reject", 16'h1000, 1'b0, 1'b0);
    release_result("busy_reject");

    // Back-pressure: hold DONE for 10 cycles.
    start_op(16'h0000, 16'h0001);
    wait_result("underflow", 4);
    check_result("underflow", 16'hFFFF, 1'b1, 1'b0);
    held_d = difference;
    held_b = borrow;
    held_o = overflow;
    ok     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && difference === held_d &&
            borrow === held_b && overflow === held_o)) ok = 1'b0;
    end
    check("backpressure_stable", {31'd0, ok}, 32'd1);

    // Release with in_valid high: not accepted until the following IDLE cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    operand_a = 16'hA5A5;
    operand_b = 16'hA5A5;
    step();
    out_ready = 1'b0;
    check("simul_idle", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    step();
    in_valid = 1'b0;
    check("simul_accepted", {31'd0, in_ready}, 32'd0);
    wait_result("equal", 4);
    check_result("equal", 16'h0000, 1'b0, 1'b0);
    release_result("equal");

    // Reset in RUN with index 2; nibbles 0 and 1 already hold 0xFF.
    start_op(16'hFFFF, 16'h0000);
    step();
    step();
    rst = 1'b1;
    #1;
    check("midrun_reset_state", {13'd0, in_ready, out_valid, borrow, overflow},
          {13'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("midrun_reset_difference", {16'd0, difference}, 32'd0);
    step();
    rst = 1'b0;
    ok  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("no_valid_after_reset", {31'd0, ok}, 32'd1);

    start_op(16'h0005, 16'h0003);
    wait_result("after_reset", 4);
    check_result("after_reset", 16'h0002, 1'b0, 1'b0);
    release_result("after_reset");

    // Randomized scoreboard with random consumer stalls.
    for (int k = 0; k < 200; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rd  = ra - rb;
      rbr = (ra < rb);
      rov = (ra[15] != rb[15]) && (rd[15] != ra[15]);
      start_op(ra, rb);
      wait_result("rand", 4);
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) step();
      check_result("rand", rd, rbr, rov);
      release_result("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
